dsp_sample_server: RTL and testbench

- Parametrised successor of the single-client DSP sample buffer.
- Holds a 2^AW-deep × DW sample memory that is filled from an external stream with an auto-incrementing write pointer.
- Serves operand reads to NCH ALU clients over per-channel req/ack/rvalid handshakes with round-robin arbitration.
- Sits between the sample input path and the ALU array; replaces the hard-wired one-ALU, 16-bit, 64-entry arrangement.

---
 rtl/dsp_sample_server_pkg.sv | 17 +
 rtl/dsp_sample_server_rr_arbiter.sv | 34 +++
 rtl/dsp_sample_server.sv | 134 +++++++++++++
 tb/tb_dsp_sample_server.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sample_server_pkg.sv
// Shared definitions for the sample server: read FSM encodings, default widths
// and the modulo helper used by the round-robin logic.
package dsp_sample_server_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Channel index wrap; v never exceeds 2*n-2 at the call sites.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/dsp_sample_server_rr_arbiter.sv
// Combinational round-robin grant: first requesting channel at or after ptr.
// The pointer register itself is owned by the parent.
module dsp_rr_arbiter
  import dsp_sample_server_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           en,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = IW'(rr_wrap(int'(ptr) + i, NCH));
      if (en && !found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_sample_server.sv
// Sample memory filled from a stream, serving operand reads to NCH ALU clients
// through a three-state read FSM with round-robin arbitration.
//
//   state  | meaning
//   IDLE   | waiting for any req; grants and latches address on the way out
//   READ   | synchronous memory read of the latched address
//   RESP   | drives rdata/rerr with a one-cycle rvalid to the granted channel
module dsp_sample_server
  import dsp_sample_server_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NCH  = 2,
  parameter int WRAP = 0
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load_en,
  input  logic              load_set,
  input  logic [AW-1:0]     load_addr,
  input  logic [DW-1:0]     din,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] addr,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    rvalid,
  output logic [DW-1:0]     rdata,
  output logic              rerr,
  output logic              busy,
  output logic [AW-1:0]     wr_ptr,
  output logic [AW:0]       fill_cnt,
  output logic              full,
  output logic              ovf
);

  localparam int          DEPTH    = 1 << AW;
  localparam int          IW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  mem_q;
  logic [1:0]     state;
  logic [NCH-1:0] gnt;
  logic [IW-1:0]  gidx;
  logic [IW-1:0]  g_q;
  logic [IW-1:0]  rr_ptr;
  logic [AW-1:0]  addr_q;
  logic           wr_en;

  assign full  = (fill_cnt == FULL_CNT);
  assign wr_en = !clr && !load_set && load_en && (!full || (WRAP != 0));

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      ovf      <= 1'b0;
    end else if (load_set) begin
      wr_ptr <= load_addr;
    end else if (load_en) begin
      if (!full) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fill_cnt <= fill_cnt + (AW+1)'(1);
      end else if (WRAP != 0) begin
        wr_ptr <= wr_ptr + AW'(1);
      end else begin
        ovf <= 1'b1;
      end
    end
  end

  // Read and write share an edge, so a write during READ returns the old word.
  always_ff @(posedge c) begin
    if (wr_en) mem[wr_ptr] <= din;
    if (state == S_READ) mem_q <= mem[addr_q];
  end

  dsp_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .en    (state == S_IDLE),
    .grant (gnt),
    .idx   (gidx)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ack    <= '0;
      rvalid <= '0;
      rdata  <= '0;
      rerr   <= 1'b0;
      busy   <= 1'b0;
      g_q    <= '0;
      addr_q <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rvalid <= '0;
          if (|gnt) begin
            ack    <= gnt;
            g_q    <= gidx;
            addr_q <= addr[gidx*AW +: AW];
            busy   <= 1'b1;
            rr_ptr <= IW'(rr_wrap(int'(gidx) + 1, NCH));
            state  <= S_READ;
          end
        end
        S_READ: begin
          ack   <= '0;
          state <= S_RESP;
        end
        S_RESP: begin
          rvalid <= NCH'(1) << g_q;
          rdata  <= mem_q;
          rerr   <= !full && ({1'b0, addr_q} >= fill_cnt);
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_sample_server.sv
// Bench for dsp_sample_server: scoreboard of expected responses for the main
// instance plus two small AW=2 instances for the full/overflow behaviour.
module tb_dsp_sample_server;

  logic        c = 1'b0;
  logic        rst_n;
  logic        clr, load_en, load_set;
  logic [5:0]  load_addr;
  logic [15:0] din;
  logic [1:0]  req;
  logic [11:0] addr;
  logic [1:0]  ack, rvalid;
  logic [15:0] rdata;
  logic        rerr, busy, full, ovf;
  logic [5:0]  wr_ptr;
  logic [6:0]  fill_cnt;

  logic        s_load_en;
  logic [15:0] s_din;
  logic [1:0]  s_req;
  logic [3:0]  s_addr;
  logic [1:0]  w0_ack, w0_rvalid, w1_ack, w1_rvalid;
  logic [15:0] w0_rdata, w1_rdata;
  logic        w0_rerr, w0_busy, w0_full, w0_ovf;
  logic        w1_rerr, w1_busy, w1_full, w1_ovf;
  logic [1:0]  w0_wr_ptr, w1_wr_ptr;
  logic [2:0]  w0_fill, w1_fill;

  always #5 c = ~c;

  dsp_sample_server #(.DW(16), .AW(6), .NCH(2), .WRAP(0)) u_dut (
    .c(c), .rst_n(rst_n), .clr(clr), .load_en(load_en), .load_set(load_set),
    .load_addr(load_addr), .din(din), .req(req), .addr(addr), .ack(ack),
    .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .busy(busy), .wr_ptr(wr_ptr),
    .fill_cnt(fill_cnt), .full(full), .ovf(ovf)
  );

  dsp_sample_server #(.DW(16), .AW(2), .NCH(2), .WRAP(0)) u_w0 (
    .c(c), .rst_n(rst_n), .clr(1'b0), .load_en(s_load_en), .load_set(1'b0),
    .load_addr(2'd0), .din(s_din), .req(s_req), .addr(s_addr), .ack(w0_ack),
    .rvalid(w0_rvalid), .rdata(w0_rdata), .rerr(w0_rerr), .busy(w0_busy),
    .wr_ptr(w0_wr_ptr), .fill_cnt(w0_fill), .full(w0_full), .ovf(w0_ovf)
  );

  dsp_sample_server #(.DW(16), .AW(2), .NCH(2), .WRAP(1)) u_w1 (
    .c(c), .rst_n(rst_n), .clr(1'b0), .load_en(s_load_en), .load_set(1'b0),
    .load_addr(2'd0), .din(s_din), .req(s_req), .addr(s_addr), .ack(w1_ack),
    .rvalid(w1_rvalid), .rdata(w1_rdata), .rerr(w1_rerr), .busy(w1_busy),
    .wr_ptr(w1_wr_ptr), .fill_cnt(w1_fill), .full(w1_full), .ovf(w1_ovf)
  );

  typedef struct {
    int          ch;
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] m_mem [64];
  int          m_ptr, m_fill, m_rr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_err(input int a);
    return (m_fill < 64) && (a >= m_fill);
  endfunction

  function automatic void m_wr(input logic [15:0] d);
    if (m_fill < 64) begin
      m_mem[m_ptr] = d;
      m_ptr        = (m_ptr + 1) % 64;
      m_fill++;
    end
  endfunction

  function automatic void m_clear();
    m_ptr  = 0;
    m_fill = 0;
  endfunction

  function automatic void push(input int ch, input int a);
    exp_t e;
    e.ch   = ch;
    e.data = m_mem[a];
    e.err  = m_err(a);
    e.cyc  = cyc;
    sb.push_back(e);
  endfunction

  always @(posedge c) cyc++;

  always @(negedge c) begin
    if (rvalid !== 2'b00) begin
      chk("rv_onehot", 32'($countones(rvalid)), 32'd1);
      if (sb.size() == 0) begin
        chk("rv_unexpected", 32'(rvalid), 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("rv_channel", 32'(rvalid), 32'(1 << sb_e.ch));
        chk("rdata", 32'(rdata), 32'(sb_e.data));
        chk("rerr", 32'(rerr), 32'(sb_e.err));
        chk("rv_latency", 32'(cyc - sb_e.cyc), 32'd2);
      end
    end
  end

  task automatic wr(input logic [15:0] d);
    load_en = 1'b1;
    din     = d;
    @(negedge c);
    load_en = 1'b0;
    m_wr(d);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge c);
    clr = 1'b0;
    m_clear();
  endtask

  task automatic lset(input logic [5:0] v);
    load_set  = 1'b1;
    load_addr = v;
    @(negedge c);
    load_set = 1'b0;
    m_ptr    = int'(v);
  endtask

  // mode 0: plain read; 1: write wdata at wr_ptr during READ; 2: clr during READ
  task automatic rd(input int ch, input int a, input int mode, input logic [15:0] wdata);
    bit got;
    got = 1'b0;
    addr[ch*6 +: 6] = 6'(a);
    req[ch] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge c);
      if (ack[ch]) got = 1'b1;
    end
    req[ch] = 1'b0;
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      return;
    end
    chk("ack_onehot", 32'(ack), 32'(1 << ch));
    chk("busy_in_txn", 32'(busy), 32'd1);
    m_rr = (ch + 1) % 2;
    if (mode == 2) begin
      clr = 1'b1;
      m_clear();
    end
    push(ch, a);
    if (mode == 1) begin
      load_en = 1'b1;
      din     = wdata;
      m_wr(wdata);
    end
    @(negedge c);
    clr     = 1'b0;
    load_en = 1'b0;
    repeat (2) @(negedge c);
  endtask

  // Both channels hold req (ch0 -> addr 0, ch1 -> addr 1) for nt grants.
  task automatic rr(input int nt);
    int n, last;
    n    = 0;
    last = 0;
    addr = '0;
    addr[6 +: 6] = 6'd1;
    req  = 2'b11;
    for (int i = 0; i < 10 * nt + 10 && n < nt; i++) begin
      @(negedge c);
      if (ack != 2'b00) begin
        chk("rr_grant", 32'(ack), 32'(1 << m_rr));
        if (n > 0) chk("rr_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        push(m_rr, m_rr);
        m_rr = (m_rr + 1) % 2;
        n++;
        if (n == nt) req = 2'b00;
      end
    end
    req = 2'b00;
    chk("rr_count", 32'(n), 32'(nt));
    repeat (3) @(negedge c);
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    clr = 1'b0; load_en = 1'b0; load_set = 1'b0; load_addr = '0; din = '0;
    req = '0; addr = '0;
    s_load_en = 1'b0; s_din = '0; s_req = '0; s_addr = '0;
    m_ptr = 0; m_fill = 0; m_rr = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;

    repeat (2) @(negedge c);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rerr", 32'(rerr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_fill", 32'(fill_cnt), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge c);

    // small instances: full and overflow, drop vs wrap
    for (int i = 1; i <= 5; i++) begin
      s_load_en = 1'b1;
      s_din     = 16'(i);
      @(negedge c);
      if (i == 4) begin
        chk("w0_full_at4", 32'(w0_full), 32'd1);
        chk("w1_full_at4", 32'(w1_full), 32'd1);
        chk("w0_ovf_at4", 32'(w0_ovf), 32'd0);
      end
    end
    s_load_en = 1'b0;
    chk("w0_ovf", 32'(w0_ovf), 32'd1);
    chk("w0_wr_ptr", 32'(w0_wr_ptr), 32'd0);
    chk("w0_fill", 32'(w0_fill), 32'd4);
    chk("w1_ovf", 32'(w1_ovf), 32'd0);
    chk("w1_full", 32'(w1_full), 32'd1);
    chk("w1_wr_ptr", 32'(w1_wr_ptr), 32'd1);
    s_addr = 4'd0;
    s_req  = 2'b01;
    got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge c);
      if (w0_ack[0]) got = 1'b1;
    end
    s_req = 2'b00;
    chk("w_ack_seen", 32'(got), 32'd1);
    repeat (2) @(negedge c);
    chk("w0_rvalid", 32'(w0_rvalid), 32'd1);
    chk("w0_rdata", 32'(w0_rdata), 32'd1);
    chk("w0_rerr", 32'(w0_rerr), 32'd0);
    chk("w1_rvalid", 32'(w1_rvalid), 32'd1);
    chk("w1_rdata", 32'(w1_rdata), 32'd5);

    // fill and read
    for (int i = 1; i <= 5; i++) wr(16'(i * 16'h0011));
    chk("fill5", 32'(fill_cnt), 32'd5);
    chk("wr_ptr5", 32'(wr_ptr), 32'd5);
    rd(0, 2, 0, '0);

    rr(6);

    // unwritten address after clear
    do_clr();
    chk("clr_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("clr_fill", 32'(fill_cnt), 32'd0);
    wr(16'hBEEF);
    wr(16'hCAFE);
    rd(0, 3, 0, '0);
    rd(1, 1, 0, '0);

    // read-before-write collision on addr 7
    do_clr();
    for (int i = 0; i < 8; i++) wr((i == 7) ? 16'h1234 : 16'(16'h0100 + i));
    lset(6'd7);
    chk("lset_wr_ptr", 32'(wr_ptr), 32'd7);
    chk("lset_fill", 32'(fill_cnt), 32'd8);
    rd(1, 7, 1, 16'hAAAA);
    rd(0, 7, 0, '0);

    // clear while a read is in flight
    rd(0, 2, 2, '0);
    chk("midclr_fill", 32'(fill_cnt), 32'd0);

    // reset during READ
    addr[0 +: 6] = 6'd0;
    req[0] = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge c);
      if (ack[0]) got = 1'b1;
    end
    req[0] = 1'b0;
    chk("rstmid_ack_seen", 32'(got), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    m_clear();
    m_rr = 0;
    repeat (3) begin
      @(negedge c);
      chk("rstmid_rvalid", 32'(rvalid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge c);
    chk("post_rst_fill", 32'(fill_cnt), 32'd0);
    rr(2);

    repeat (4) @(negedge c);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
